// File: rtl/gamma_lut_corrector.sv
// gamma_lut_corrector: programmable per-channel gamma curve applied by
// piecewise-linear interpolation between 2^KBITS+1 knots per channel.
// Knot tables are double-buffered: host writes land in the shadow bank and the
// shadow bank becomes active on the first start-of-frame pixel after a commit.
// Fixed 3-cycle streaming pipeline, no backpressure.
// Optional feature macro: GAMMA_LUT_READBACK_EN (adds cfg_rdata shadow readback).
module gamma_lut_corrector #(
    parameter int DW    = 12,
    parameter int NCH   = 3,
    parameter int KBITS = 6,
    parameter int CHW   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inpvalid,
    input  logic                insof,
    input  logic [NCH*DW-1:0]   din,
    input  logic                bypass,
    input  logic                cfg_we,
    input  logic [CHW-1:0]      cfg_chan,
    input  logic [KBITS:0]      cfg_addr,
    input  logic [DW-1:0]       cfg_wdata,
    input  logic                cfg_commit,
    output logic                cfg_busy,
    output logic                outvalid,
    output logic                outsof,
    output logic [NCH*DW-1:0]   dout
`ifdef GAMMA_LUT_READBACK_EN
    ,
    output logic [DW-1:0]       cfg_rdata
`endif
);

    localparam int F  = DW - KBITS;        // fraction bits per pixel
    localparam int KN = (2 ** KBITS) + 1;  // knots per channel
    localparam int PW = DW + F + 1;        // signed product width

    // Rounding constant 2^(F-1) for the fraction shift.
    localparam logic signed [PW-1:0] RND = {{(PW-F){1'b0}}, 1'b1, {(F-1){1'b0}}};

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   bank_q;          // active bank; shadow is ~bank_q
    logic   bank_d;
    logic   swap_s;
    logic   range_ok_s;
    logic   wr_ok_s;

    // Knot storage: [bank][channel][knot]. Not reset; software loads it.
    logic [DW-1:0] knot_q [2][NCH][KN];

    // Pipeline control and data that travels alongside the arithmetic.
    logic              v1_q, sof1_q, byp1_q;
    logic [NCH*DW-1:0] din1_q;
    logic              v2_q, sof2_q, byp2_q;
    logic [NCH*DW-1:0] din2_q;
    logic              outvalid_q, outsof_q;
    logic [NCH*DW-1:0] dout_q;
    logic [NCH*DW-1:0] y_s;

    // Bank-swap FSM: arm on commit, swap on the first SOF pixel while armed.
    always_comb begin
        state_d = state_q;
        swap_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_commit) begin
                    state_d = S_PENDING;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PENDING: begin
                if (inpvalid && insof) begin
                    state_d = S_IDLE;
                    swap_s  = 1'b1;
                end else begin
                    state_d = S_PENDING;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // On a swap edge the pixel reads the new bank, i.e. the old shadow bank.
    assign bank_d   = bank_q ^ swap_s;
    assign cfg_busy = (state_q == S_PENDING);

    // Host write qualification: in-range target and no swap pending.
    always_comb begin
        range_ok_s = 1'b0;
        wr_ok_s    = 1'b0;
        if ((int'(cfg_addr) < KN) && (int'(cfg_chan) < NCH)) begin
            range_ok_s = 1'b1;
        end else begin
            range_ok_s = 1'b0;
        end
        if (cfg_we && range_ok_s && (state_q == S_IDLE)) begin
            wr_ok_s = 1'b1;
        end else begin
            wr_ok_s = 1'b0;
        end
    end

    // Knot RAM write port into the shadow bank.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            knot_q[~bank_q][cfg_chan][cfg_addr] <= cfg_wdata;
        end
    end

    // Per-channel datapath: knot reads, slope multiply, rounding and add.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [KBITS:0]         idx_s;
        logic [DW-1:0]          k0_1_q, k1_1_q;
        logic [DW-1:0]          k0_2_q;
        logic signed [PW-1:0]   diff_s, prod_s, prod_2_q, rnd_s, shf_s;

        assign idx_s = {1'b0, din[c*DW+F +: KBITS]};

        // Stage 1: registered reads of the bracketing knots.
        always_ff @(posedge clk) begin
            k0_1_q <= knot_q[bank_d][c][idx_s];
            k1_1_q <= knot_q[bank_d][c][idx_s + {{KBITS{1'b0}}, 1'b1}];
        end

        // Slope may be negative for decreasing curves.
        assign diff_s = $signed({{(F+1){1'b0}}, k1_1_q}) - $signed({{(F+1){1'b0}}, k0_1_q});
        assign prod_s = diff_s * $signed({{(DW+1){1'b0}}, din1_q[c*DW +: F]});

        // Stage 2: hold the base knot and the slope*fraction product.
        always_ff @(posedge clk) begin
            k0_2_q   <= k0_1_q;
            prod_2_q <= prod_s;
        end

        // Round-to-nearest then floor shift; result stays between the knots.
        assign rnd_s = prod_2_q + RND;
        assign shf_s = rnd_s >>> F;
        assign y_s[c*DW +: DW] = DW'(shf_s + $signed({{(F+1){1'b0}}, k0_2_q}));
    end

    // Control pipeline, bank state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bank_q     <= 1'b0;
            v1_q       <= 1'b0;
            sof1_q     <= 1'b0;
            byp1_q     <= 1'b0;
            din1_q     <= {(NCH*DW){1'b0}};
            v2_q       <= 1'b0;
            sof2_q     <= 1'b0;
            byp2_q     <= 1'b0;
            din2_q     <= {(NCH*DW){1'b0}};
            outvalid_q <= 1'b0;
            outsof_q   <= 1'b0;
            dout_q     <= {(NCH*DW){1'b0}};
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            v1_q       <= inpvalid;
            sof1_q     <= insof & inpvalid;
            byp1_q     <= bypass;
            din1_q     <= din;
            v2_q       <= v1_q;
            sof2_q     <= sof1_q;
            byp2_q     <= byp1_q;
            din2_q     <= din1_q;
            outvalid_q <= v2_q;
            outsof_q   <= sof2_q;
            if (v2_q) begin
                dout_q <= byp2_q ? din2_q : y_s;
            end
        end
    end

    assign outvalid = outvalid_q;
    assign outsof   = outsof_q;
    assign dout     = dout_q;

`ifdef GAMMA_LUT_READBACK_EN
    logic [DW-1:0] rdata_q;

    // Shadow-bank readback, refreshed on every cycle without a write strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= {DW{1'b0}};
        end else if (!cfg_we) begin
            if (range_ok_s) begin
                rdata_q <= knot_q[~bank_q][cfg_chan][cfg_addr];
            end else begin
                rdata_q <= {DW{1'b0}};
            end
        end
    end

    assign cfg_rdata = rdata_q;
`endif

endmodule
